// File: rtl/fetch_unit_if.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit_if
// Description : Bundles the fetch unit's external handshakes: the branch
//               redirect from MEM, the instruction-memory req/ack port and
//               the valid/ready port toward the IF/ID pipeline register.
//               master = fetch unit view, slave = surrounding pipeline/memory.
// Revision    : 1.0 - initial release
// ============================================================================
interface fetch_unit_if #(
    parameter int PC_WIDTH    = 64,
    parameter int INSTR_WIDTH = 32
);
    // Branch redirect from the MEM stage
    logic                   redirect_valid;
    logic [PC_WIDTH-1:0]    redirect_pc;

    // Instruction memory request/acknowledge
    logic                   imem_req;
    logic [PC_WIDTH-1:0]    imem_addr;
    logic                   imem_ack;
    logic [INSTR_WIDTH-1:0] imem_rdata;

    // Fetched instruction stream toward IF/ID
    logic                   out_valid;
    logic                   out_ready;
    logic [PC_WIDTH-1:0]    out_pc;
    logic [INSTR_WIDTH-1:0] out_instr;

    modport master (
        input  redirect_valid, redirect_pc,
        input  imem_ack, imem_rdata,
        input  out_ready,
        output imem_req, imem_addr,
        output out_valid, out_pc, out_instr
    );

    modport slave (
        output redirect_valid, redirect_pc,
        output imem_ack, imem_rdata,
        output out_ready,
        input  imem_req, imem_addr,
        input  out_valid, out_pc, out_instr
    );
endinterface
`default_nettype wire

// File: rtl/fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : fetch_unit
// Description : Instruction-fetch front end. Owns the fetch PC, issues one
//               request at a time to instruction memory, buffers returned
//               {pc, instr} pairs in a QDEPTH-entry queue and presents the
//               head to IF/ID. A redirect flushes the queue and squashes any
//               outstanding request.
// Ports       : clk    - clock
//               reset  - synchronous active-high reset
//               bus    - fetch_unit_if.master (redirect, imem req/ack,
//                        out valid/ready stream)
// Revision    : 1.0 - initial release
// ============================================================================
module fetch_unit #(
    parameter int                  PC_WIDTH    = 64,
    parameter int                  INSTR_WIDTH = 32,
    parameter logic [PC_WIDTH-1:0] RESET_PC    = '0,
    parameter int                  QDEPTH      = 4
) (
    input  wire logic    clk,
    input  wire logic    reset,
    fetch_unit_if.master bus
);

    localparam int                  c_ptr_w   = $clog2(QDEPTH);
    localparam int                  c_cnt_w   = $clog2(QDEPTH) + 1;
    localparam logic [c_cnt_w-1:0]  c_full    = c_cnt_w'(QDEPTH);
    localparam logic [PC_WIDTH-1:0] c_pc_step = PC_WIDTH'(4);

    typedef enum logic [1:0] {
        S_IDLE   = 2'd0,
        S_WAIT   = 2'd1,
        S_SQUASH = 2'd2
    } state_t;

    state_t                 r_state;
    logic [PC_WIDTH-1:0]    r_fetch_pc;
    logic [PC_WIDTH-1:0]    r_req_addr;
    logic [c_cnt_w-1:0]     r_count;
    logic [c_ptr_w-1:0]     r_wr_ptr;
    logic [c_ptr_w-1:0]     r_rd_ptr;
    logic [PC_WIDTH-1:0]    r_q_pc    [QDEPTH];
    logic [INSTR_WIDTH-1:0] r_q_instr [QDEPTH];

    logic                   w_req;
    logic [PC_WIDTH-1:0]    w_addr;
    logic                   w_push;
    logic [PC_WIDTH-1:0]    w_push_pc;
    logic                   w_out_valid;
    logic                   w_pop;
    logic [PC_WIDTH-1:0]    w_redirect_pc;

    // Targets are word aligned; low bits of the branch adder result are dropped.
    assign w_redirect_pc = {bus.redirect_pc[PC_WIDTH-1:2], 2'b00};

    // Request decode. In IDLE the request is combinational on redirect so a
    // taken branch never launches a fetch down the wrong path. Once a request
    // is outstanding it stays up with a stable address until acknowledged.
    always_comb begin
        w_req     = 1'b0;
        w_addr    = r_fetch_pc;
        w_push    = 1'b0;
        w_push_pc = r_fetch_pc;
        case (r_state)
            S_IDLE: begin
                w_req     = (r_count < c_full) && !bus.redirect_valid;
                w_addr    = r_fetch_pc;
                w_push    = w_req && bus.imem_ack;
                w_push_pc = r_fetch_pc;
            end
            S_WAIT: begin
                w_req     = 1'b1;
                w_addr    = r_req_addr;
                w_push    = bus.imem_ack && !bus.redirect_valid;
                w_push_pc = r_req_addr;
            end
            S_SQUASH: begin
                // Stale request must complete; its data is thrown away.
                w_req     = 1'b1;
                w_addr    = r_req_addr;
            end
            default: begin
                w_req     = 1'b0;
            end
        endcase
        if (reset) begin
            w_req  = 1'b0;
            w_push = 1'b0;
        end
    end

    assign w_out_valid   = (r_count != '0);
    assign w_pop         = w_out_valid && bus.out_ready;

    assign bus.imem_req  = w_req;
    assign bus.imem_addr = w_addr;
    assign bus.out_valid = w_out_valid;
    assign bus.out_pc    = w_out_valid ? r_q_pc[r_rd_ptr]    : '0;
    assign bus.out_instr = w_out_valid ? r_q_instr[r_rd_ptr] : '0;

    // Queue storage needs no reset; validity is tracked by r_count.
    always_ff @(posedge clk) begin
        if (w_push && !bus.redirect_valid) begin
            r_q_pc[r_wr_ptr]    <= w_push_pc;
            r_q_instr[r_wr_ptr] <= bus.imem_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_fetch_pc <= RESET_PC;
            r_req_addr <= '0;
            r_count    <= '0;
            r_wr_ptr   <= '0;
            r_rd_ptr   <= '0;
        end else begin
            // Queue bookkeeping; a redirect wins over any push or pop.
            if (bus.redirect_valid) begin
                r_count  <= '0;
                r_wr_ptr <= '0;
                r_rd_ptr <= '0;
            end else begin
                if (w_push) begin
                    r_wr_ptr <= r_wr_ptr + 1'b1;
                end
                if (w_pop) begin
                    r_rd_ptr <= r_rd_ptr + 1'b1;
                end
                case ({w_push, w_pop})
                    2'b10:   r_count <= r_count + 1'b1;
                    2'b01:   r_count <= r_count - 1'b1;
                    default: r_count <= r_count;
                endcase
            end

            case (r_state)
                S_IDLE: begin
                    if (bus.redirect_valid) begin
                        r_fetch_pc <= w_redirect_pc;
                    end else if (w_req) begin
                        if (bus.imem_ack) begin
                            r_fetch_pc <= r_fetch_pc + c_pc_step;
                        end else begin
                            r_req_addr <= r_fetch_pc;
                            r_state    <= S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (bus.imem_ack) begin
                        r_state    <= S_IDLE;
                        r_fetch_pc <= bus.redirect_valid ? w_redirect_pc
                                                         : r_req_addr + c_pc_step;
                    end else if (bus.redirect_valid) begin
                        r_fetch_pc <= w_redirect_pc;
                        r_state    <= S_SQUASH;
                    end
                end
                S_SQUASH: begin
                    if (bus.redirect_valid) begin
                        r_fetch_pc <= w_redirect_pc;
                    end
                    if (bus.imem_ack) begin
                        r_state <= S_IDLE;
                    end
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Requests are only launched with a free slot and one outstanding at a
    // time, so a push can never find the queue full.
    always_ff @(posedge clk) begin
        if (!reset && w_push && !bus.redirect_valid) begin
            assert (r_count < c_full)
                else $error("fetch_unit: push into full queue");
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fetch_unit.sv
`default_nettype none
// ============================================================================
// Module      : tb_fetch_unit
// Description : Directed self-checking bench for fetch_unit. Memory returns
//               a deterministic word per address; each task drives one
//               scenario and compares against hand-computed values.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fetch_unit;

    logic clk = 1'b0;
    logic reset;
    int   total = 0;
    int   bad   = 0;

    fetch_unit_if #(.PC_WIDTH(64), .INSTR_WIDTH(32)) bus ();

    fetch_unit #(
        .PC_WIDTH    (64),
        .INSTR_WIDTH (32),
        .RESET_PC    (64'h0),
        .QDEPTH      (4)
    ) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] instr_of(input logic [63:0] a);
        return 32'hC0DE_0000 ^ a[31:0] ^ {a[7:0], 24'h0};
    endfunction

    assign bus.imem_rdata = instr_of(bus.imem_addr);

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic do_reset();
        reset              = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        tick();
        tick();
        reset = 1'b0;
        settle();
    endtask

    task automatic test_reset();
        bus.imem_ack = 1'b1; bus.out_ready = 1'b1;
        bus.redirect_valid = 1'b0; bus.redirect_pc = '0;
        reset = 1'b1;
        tick(); tick(); settle();
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rst_req got=%b want=0", bus.imem_req); end
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rst_valid got=%b want=0", bus.out_valid); end
        total++; if (bus.out_pc !== 64'h0) begin bad++; $display("FAIL rst_pc got=%h want=0", bus.out_pc); end
        total++; if (bus.out_instr !== 32'h0) begin bad++; $display("FAIL rst_instr got=%h want=0", bus.out_instr); end
        reset = 1'b0; settle();
        total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL rst_rel_req got=%b want=1", bus.imem_req); end
        total++; if (bus.imem_addr !== 64'h0) begin bad++; $display("FAIL rst_rel_addr got=%h want=0", bus.imem_addr); end
    endtask

    task automatic test_stream();
        bus.imem_ack = 1'b1; bus.out_ready = 1'b1;
        do_reset();
        for (int i = 0; i < 6; i++) begin
            total++; if (bus.imem_req !== 1'b1) begin bad++; $display("FAIL stream_req cyc=%0d got=%b want=1", i, bus.imem_req); end
            total++; if (bus.imem_addr !== 64'(4*i)) begin bad++; $display("FAIL stream_addr cyc=%0d got=%h want=%h", i, bus.imem_addr, 64'(4*i)); end
            if (i > 0) begin
                total++; if (bus.out_valid !== 1'b1) begin bad++; $display("FAIL stream_valid cyc=%0d got=%b want=1", i, bus.out_valid); end
                total++; if (bus.out_pc !== 64'(4*(i-1))) begin bad++; $display("FAIL stream_pc cyc=%0d got=%h want=%h", i, bus.out_pc, 64'(4*(i-1))); end
                total++; if (bus.out_instr !== instr_of(64'(4*(i-1)))) begin bad++; $display("FAIL stream_instr cyc=%0d got=%h want=%h", i, bus.out_instr, instr_of(64'(4*(i-1)))); end
            end
            tick();
        end
    endtask

    task automatic test_backpressure();
        bus.imem_ack = 1'b1; bus.out_ready = 1'b0;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            total++; if (bus.imem_addr !== 64'(4*i) || bus.imem_req !== 1'b1) begin bad++; $display("FAIL bp_fill cyc=%0d req=%b addr=%h want req=1 addr=%h", i, bus.imem_req, bus.imem_addr, 64'(4*i)); end
            tick();
        end
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL bp_full_req got=%b want=0", bus.imem_req); end
        total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0) begin bad++; $display("FAIL bp_full_head valid=%b pc=%h want 1/0", bus.out_valid, bus.out_pc); end
        tick();
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL bp_hold_req got=%b want=0", bus.imem_req); end
        bus.out_ready = 1'b1; settle();
        for (int j = 0; j < 6; j++) begin
            total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'(4*j)) begin bad++; $display("FAIL bp_drain j=%0d valid=%b pc=%h want 1/%h", j, bus.out_valid, bus.out_pc, 64'(4*j)); end
            if (j == 0) begin
                total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL bp_resume0_req got=%b want=0", bus.imem_req); end
            end
            if (j == 1) begin
                total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'd16) begin bad++; $display("FAIL bp_resume_addr req=%b addr=%h want 1/10", bus.imem_req, bus.imem_addr); end
            end
            tick();
        end
    endtask

    task automatic test_wait();
        bus.imem_ack = 1'b1; bus.out_ready = 1'b1;
        do_reset();
        tick(); tick();
        bus.imem_ack = 1'b0; settle();
        for (int k = 0; k < 3; k++) begin
            total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'd8) begin bad++; $display("FAIL wait_hold k=%0d req=%b addr=%h want 1/8", k, bus.imem_req, bus.imem_addr); end
            if (k == 2) begin
                total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL wait_empty got=%b want=0", bus.out_valid); end
            end
            tick();
        end
        bus.imem_ack = 1'b1; settle();
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'd8) begin bad++; $display("FAIL wait_ack_addr req=%b addr=%h want 1/8", bus.imem_req, bus.imem_addr); end
        tick();
        total++; if (bus.imem_addr !== 64'd12) begin bad++; $display("FAIL wait_next_addr got=%h want=c", bus.imem_addr); end
        total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'd8) begin bad++; $display("FAIL wait_push_pc valid=%b pc=%h want 1/8", bus.out_valid, bus.out_pc); end
        total++; if (bus.out_instr !== instr_of(64'd8)) begin bad++; $display("FAIL wait_push_instr got=%h want=%h", bus.out_instr, instr_of(64'd8)); end
        tick();
        total++; if (bus.out_pc !== 64'd12) begin bad++; $display("FAIL wait_single_push got=%h want=c", bus.out_pc); end
    endtask

    task automatic test_redirect_wait();
        bus.imem_ack = 1'b1; bus.out_ready = 1'b0;
        do_reset();
        tick(); tick();
        bus.imem_ack = 1'b0; settle();
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0) begin bad++; $display("FAIL rw_pre_head valid=%b pc=%h want 1/0", bus.out_valid, bus.out_pc); end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h100; settle();
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'd8) begin bad++; $display("FAIL rw_wait_req req=%b addr=%h want 1/8", bus.imem_req, bus.imem_addr); end
        tick();
        bus.redirect_valid = 1'b0; settle();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rw_flush got=%b want=0", bus.out_valid); end
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'd8) begin bad++; $display("FAIL rw_squash_req req=%b addr=%h want 1/8", bus.imem_req, bus.imem_addr); end
        tick();
        bus.imem_ack = 1'b1; settle();
        tick();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rw_stale_drop got=%b want=0", bus.out_valid); end
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h100) begin bad++; $display("FAIL rw_target_addr req=%b addr=%h want 1/100", bus.imem_req, bus.imem_addr); end
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h100) begin bad++; $display("FAIL rw_target_pc valid=%b pc=%h want 1/100", bus.out_valid, bus.out_pc); end
        total++; if (bus.out_instr !== instr_of(64'h100)) begin bad++; $display("FAIL rw_target_instr got=%h want=%h", bus.out_instr, instr_of(64'h100)); end
    endtask

    task automatic test_redirect_ack_pop();
        bus.imem_ack = 1'b1; bus.out_ready = 1'b1;
        do_reset();
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0) begin bad++; $display("FAIL rap_head valid=%b pc=%h want 1/0", bus.out_valid, bus.out_pc); end
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h203; settle();
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rap_req_suppress got=%b want=0", bus.imem_req); end
        tick();
        bus.redirect_valid = 1'b0; settle();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rap_flush got=%b want=0", bus.out_valid); end
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h200) begin bad++; $display("FAIL rap_align_addr req=%b addr=%h want 1/200", bus.imem_req, bus.imem_addr); end
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h200) begin bad++; $display("FAIL rap_target_pc valid=%b pc=%h want 1/200", bus.out_valid, bus.out_pc); end
        bus.imem_ack = 1'b0; settle();
        tick();
        bus.imem_ack = 1'b1; bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h300; settle();
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h204) begin bad++; $display("FAIL rap_wait_addr req=%b addr=%h want 1/204", bus.imem_req, bus.imem_addr); end
        tick();
        bus.redirect_valid = 1'b0; settle();
        total++; if (bus.out_valid !== 1'b0) begin bad++; $display("FAIL rap_wait_discard got=%b want=0", bus.out_valid); end
        total++; if (bus.imem_addr !== 64'h300) begin bad++; $display("FAIL rap_wait_target got=%h want=300", bus.imem_addr); end
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h300) begin bad++; $display("FAIL rap_wait_pc valid=%b pc=%h want 1/300", bus.out_valid, bus.out_pc); end
    endtask

    task automatic test_reset_squash();
        bus.imem_ack = 1'b1; bus.out_ready = 1'b0;
        do_reset();
        tick();
        bus.imem_ack = 1'b0; settle();
        tick();
        bus.redirect_valid = 1'b1; bus.redirect_pc = 64'h400; settle();
        tick();
        bus.redirect_valid = 1'b0; reset = 1'b1; settle();
        total++; if (bus.imem_req !== 1'b0) begin bad++; $display("FAIL rs_req_in_reset got=%b want=0", bus.imem_req); end
        tick();
        total++; if (bus.out_valid !== 1'b0 || bus.imem_req !== 1'b0) begin bad++; $display("FAIL rs_after_reset valid=%b req=%b want 0/0", bus.out_valid, bus.imem_req); end
        reset = 1'b0; bus.imem_ack = 1'b1; settle();
        total++; if (bus.imem_req !== 1'b1 || bus.imem_addr !== 64'h0) begin bad++; $display("FAIL rs_restart req=%b addr=%h want 1/0", bus.imem_req, bus.imem_addr); end
        tick();
        total++; if (bus.out_valid !== 1'b1 || bus.out_pc !== 64'h0 || bus.imem_addr !== 64'd4) begin bad++; $display("FAIL rs_restart_push valid=%b pc=%h addr=%h want 1/0/4", bus.out_valid, bus.out_pc, bus.imem_addr); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        reset = 1'b1;
        bus.redirect_valid = 1'b0;
        bus.redirect_pc    = '0;
        bus.imem_ack       = 1'b0;
        bus.out_ready      = 1'b0;
        test_reset();
        test_stream();
        test_backpressure();
        test_wait();
        test_redirect_wait();
        test_redirect_ack_pop();
        test_reset_squash();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
